// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in / parallel-out deserializer.
//   state_e   : two-state FSM encoding (COLLECT accepts bits, FULL stalls the source)
//   cnt_width : width of the in-word bit counter for a given word width
package sipo_pkg;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_FULL    = 1'b1
    } state_e;

    // Bit counter spans 0..width-1.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/pipo_load_reg.sv
// Parallel-in / parallel-out output register with load enable.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low clear
//   load_i : capture d_i on this edge
//   d_i    : word to capture
//   q_o    : held word
module pipo_load_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next value: new word on load, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = d_i;
        end else begin
            q_d = q_q;
        end
    end

    // Output word register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= {WIDTH{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out front end. Gathers WIDTH serial bits into a word and
// hands it downstream over valid/ready; stalls the serial source while a
// finished word cannot be handed off; a sync strobe realigns word boundaries.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   ser_in/ser_valid      : serial bit and its qualifier
//   ser_sync              : with ser_valid, this bit starts a new word
//   ser_ready             : a bit is accepted this cycle when ser_valid is high
//   par_out/par_valid     : registered word and its valid flag
//   par_ready             : downstream consumes par_out this cycle
//   resync_drop           : one-cycle pulse when a sync discarded a partial word
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             ser_sync,
    output logic             ser_ready,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             resync_drop
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_valid_q, par_valid_d;
    logic             drop_q, drop_d;

    logic             accept_s;
    logic             slot_free_s;
    logic [WIDTH-1:0] shift_base_s;
    logic [WIDTH-1:0] shift_word_s;
    logic             load_s;
    logic [WIDTH-1:0] load_word_s;

    assign ser_ready   = (state_q == S_COLLECT);
    assign accept_s    = ser_valid && ser_ready;
    assign slot_free_s = !par_valid_q || par_ready;

    // Shift path; a sync bit starts from an empty register so the discarded
    // partial bits cannot leak into the new word.
    always_comb begin
        shift_base_s = sr_q;
        shift_word_s = sr_q;
        if (ser_sync) begin
            shift_base_s = {WIDTH{1'b0}};
        end else begin
            shift_base_s = sr_q;
        end
        if (MSB_FIRST) begin
            shift_word_s = {shift_base_s[WIDTH-2:0], ser_in};
        end else begin
            shift_word_s = {ser_in, shift_base_s[WIDTH-1:1]};
        end
    end

    // FSM next state, shift register, bit counter and output handshake.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        drop_d      = 1'b0;
        load_s      = 1'b0;
        load_word_s = sr_q;
        case (state_q)
            S_COLLECT: begin
                if (accept_s) begin
                    sr_d = shift_word_s;
                    if (ser_sync) begin
                        // Sync takes priority over completion, so a word never
                        // finishes on its own first bit.
                        cnt_d  = CNT_ONE;
                        drop_d = (cnt_q != CNT_ZERO);
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d = CNT_ZERO;
                        if (slot_free_s) begin
                            load_s      = 1'b1;
                            load_word_s = shift_word_s;
                        end else begin
                            // Park the word in sr until downstream drains.
                            state_d = S_FULL;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    sr_d = sr_q;
                end
            end
            S_FULL: begin
                if (par_ready) begin
                    load_s      = 1'b1;
                    load_word_s = sr_q;
                    state_d     = S_COLLECT;
                end else begin
                    state_d = S_FULL;
                end
            end
            default: begin
                state_d = S_COLLECT;
            end
        endcase

        if (load_s) begin
            par_valid_d = 1'b1;
        end else if (par_ready) begin
            par_valid_d = 1'b0;
        end else begin
            par_valid_d = par_valid_q;
        end
    end

    // State, shift register, counter, valid flag and drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_COLLECT;
            sr_q        <= {WIDTH{1'b0}};
            cnt_q       <= CNT_ZERO;
            par_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            par_valid_q <= par_valid_d;
            drop_q      <= drop_d;
        end
    end

    pipo_load_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load_s),
        .d_i    (load_word_s),
        .q_o    (par_out)
    );

    assign par_valid   = par_valid_q;
    assign resync_drop = drop_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: one MSB-first instance (a_*) and one
// LSB-first instance (b_*), both WIDTH=4, sharing clock and reset.
module tb_sipo_deserializer;

    logic       clk;
    logic       rst_n;

    logic       a_ser_in, a_ser_valid, a_ser_sync, a_ser_ready;
    logic [3:0] a_par_out;
    logic       a_par_valid, a_par_ready, a_resync_drop;

    logic       b_ser_in, b_ser_valid, b_ser_sync, b_ser_ready;
    logic [3:0] b_par_out;
    logic       b_par_valid, b_par_ready, b_resync_drop;

    int n_checks;
    int n_fail;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .ser_in      (a_ser_in),
        .ser_valid   (a_ser_valid),
        .ser_sync    (a_ser_sync),
        .ser_ready   (a_ser_ready),
        .par_out     (a_par_out),
        .par_valid   (a_par_valid),
        .par_ready   (a_par_ready),
        .resync_drop (a_resync_drop)
    );

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .ser_in      (b_ser_in),
        .ser_valid   (b_ser_valid),
        .ser_sync    (b_ser_sync),
        .ser_ready   (b_ser_ready),
        .par_out     (b_par_out),
        .par_valid   (b_par_valid),
        .par_ready   (b_par_ready),
        .resync_drop (b_resync_drop)
    );

    // 10 ns clock; rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one bit to instance A, take one edge, settle 1 ns.
    task automatic send_a(input logic b, input logic s);
        a_ser_in    = b;
        a_ser_sync  = s;
        a_ser_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_b(input logic b);
        b_ser_in    = b;
        b_ser_sync  = 1'b0;
        b_ser_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_ser_valid = 1'b0;
        a_ser_sync  = 1'b0;
        a_ser_in    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] words [3];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        words[0] = 4'b1011;
        words[1] = 4'b1111;
        words[2] = 4'b1001;

        rst_n       = 1'b0;
        a_ser_in    = 1'b0; a_ser_valid = 1'b0; a_ser_sync = 1'b0; a_par_ready = 1'b1;
        b_ser_in    = 1'b0; b_ser_valid = 1'b0; b_ser_sync = 1'b0; b_par_ready = 1'b1;

        // Reset state.
        #3;
        chk("rst_par_out",   {28'd0, a_par_out},     32'd0);
        chk("rst_par_valid", {31'd0, a_par_valid},   32'd0);
        chk("rst_drop",      {31'd0, a_resync_drop}, 32'd0);
        chk("rst_ser_ready", {31'd0, a_ser_ready},   32'd1);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1. Single word 1,0,0,1.
        send_a(1'b1, 1'b0);
        send_a(1'b0, 1'b0);
        send_a(1'b0, 1'b0);
        chk("t1_no_valid_early", {31'd0, a_par_valid}, 32'd0);
        send_a(1'b1, 1'b0);
        chk("t1_par_valid", {31'd0, a_par_valid}, 32'd1);
        chk("t1_par_out",   {28'd0, a_par_out},   32'h9);
        idle_a();
        chk("t1_valid_one_cycle", {31'd0, a_par_valid}, 32'd0);

        // 2. Streaming three words back to back.
        for (int w = 0; w < 3; w++) begin
            for (int i = 3; i >= 0; i--) begin
                chk($sformatf("t2_ser_ready_w%0d_b%0d", w, i), {31'd0, a_ser_ready}, 32'd1);
                send_a(words[w][i], 1'b0);
                if (i == 0) begin
                    chk($sformatf("t2_valid_w%0d", w), {31'd0, a_par_valid}, 32'd1);
                    chk($sformatf("t2_word_w%0d", w),  {28'd0, a_par_out},   {28'd0, words[w]});
                end else begin
                    chk($sformatf("t2_idle_w%0d_b%0d", w, i), {31'd0, a_par_valid}, 32'd0);
                end
            end
        end
        idle_a();
        chk("t2_drained", {31'd0, a_par_valid}, 32'd0);

        // 3. Back-pressure.
        a_par_ready = 1'b0;
        for (int i = 3; i >= 0; i--) send_a(words[0][i], 1'b0);
        chk("t3_first_valid", {31'd0, a_par_valid}, 32'd1);
        chk("t3_first_word",  {28'd0, a_par_out},   32'hB);
        chk("t3_still_ready", {31'd0, a_ser_ready}, 32'd1);
        for (int i = 3; i >= 0; i--) send_a(words[1][i], 1'b0);
        chk("t3_hold_word",   {28'd0, a_par_out},   32'hB);
        chk("t3_full_stall",  {31'd0, a_ser_ready}, 32'd0);
        chk("t3_hold_valid",  {31'd0, a_par_valid}, 32'd1);
        a_ser_valid = 1'b0;
        idle_a();
        chk("t3_stall_holds", {31'd0, a_ser_ready}, 32'd0);
        a_par_ready = 1'b1;
        idle_a();
        a_par_ready = 1'b0;
        chk("t3_second_word",  {28'd0, a_par_out},   32'hF);
        chk("t3_second_valid", {31'd0, a_par_valid}, 32'd1);
        chk("t3_ready_again",  {31'd0, a_ser_ready}, 32'd1);
        a_par_ready = 1'b1;
        idle_a();
        chk("t3_drained", {31'd0, a_par_valid}, 32'd0);

        // 4. Resync after a partial 1,1.
        send_a(1'b1, 1'b0);
        send_a(1'b1, 1'b0);
        chk("t4_no_drop_yet", {31'd0, a_resync_drop}, 32'd0);
        send_a(1'b0, 1'b1);
        chk("t4_drop_pulse", {31'd0, a_resync_drop}, 32'd1);
        chk("t4_no_partial", {31'd0, a_par_valid},   32'd0);
        send_a(1'b1, 1'b0);
        chk("t4_drop_one_cycle", {31'd0, a_resync_drop}, 32'd0);
        send_a(1'b1, 1'b0);
        chk("t4_not_done", {31'd0, a_par_valid}, 32'd0);
        send_a(1'b0, 1'b0);
        chk("t4_valid", {31'd0, a_par_valid}, 32'd1);
        chk("t4_word",  {28'd0, a_par_out},   32'h6);
        a_ser_valid = 1'b0;

        // 5. LSB-first instance: 1,0,0,0 -> 0001.
        send_b(1'b1);
        send_b(1'b0);
        send_b(1'b0);
        send_b(1'b0);
        b_ser_valid = 1'b0;
        chk("t5_valid", {31'd0, b_par_valid}, 32'd1);
        chk("t5_word",  {28'd0, b_par_out},   32'h1);

        // 6. Reset mid-word with a pending word 0110 held.
        a_par_ready = 1'b0;
        send_a(1'b1, 1'b0);
        send_a(1'b0, 1'b0);
        chk("t6_pending_word", {28'd0, a_par_out}, 32'h6);
        a_ser_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, a_par_valid},   32'd0);
        chk("t6_rst_out",   {28'd0, a_par_out},     32'd0);
        chk("t6_rst_drop",  {31'd0, a_resync_drop}, 32'd0);
        #2 rst_n = 1'b1;
        a_par_ready = 1'b1;
        @(posedge clk);
        #1;
        send_a(1'b1, 1'b0);
        send_a(1'b1, 1'b0);
        send_a(1'b0, 1'b0);
        send_a(1'b0, 1'b0);
        chk("t6_new_valid", {31'd0, a_par_valid}, 32'd1);
        chk("t6_new_word",  {28'd0, a_par_out},   32'hC);
        chk("t6_no_drop",   {31'd0, a_resync_drop}, 32'd0);
        idle_a();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
